// File: rtl/seg_scan_driver_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
package seg_pkg;

  localparam int unsigned MAX_DIGITS = 32;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;

  typedef enum logic {GUARD, DRIVE} scan_state_t;

  // Active-low anode vector with only bit idx low; out-of-range idx gives all high.
  function automatic logic [MAX_DIGITS-1:0] onehot_low(input int unsigned idx,
                                                      input int unsigned n);
    logic [MAX_DIGITS-1:0] one;
    one = {{(MAX_DIGITS-1){1'b0}}, 1'b1};
    return (idx < n) ? ~(one << idx) : '1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_rise_detect.sv
// Rising-edge detector for a level strobe in the MegaClk domain.
module rise_detect (
  input  logic MegaClk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge MegaClk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= level_i;
  end

  assign pulse_o = level_i && !prev_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with blink, PWM
// brightness and a one-cycle blank at every digit change.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 8,
  parameter int unsigned PWM_BITS   = 3
) (
  input  logic                  MegaClk,
  input  logic                  reset,
  input  logic                  scan_tick,
  input  logic                  blink_clk,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic [SEG_W-1:0]      digit_bits [NUM_DIGITS],
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic [SEG_W-1:0]      seg_n
);

  localparam int unsigned           DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [PWM_BITS-1:0]   SUB_LAST  = '1;
  localparam logic [SEG_W-1:0]      SEG_BLANK = {SEG_W{SEG_OFF[0]}};
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

  logic                  tick;
  scan_state_t           state_q, state_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [PWM_BITS-1:0]   sub_q, sub_d;
  logic [PWM_BITS-1:0]   bri_q, bri_d;
  logic [SEG_W-1:0]      pat_q, pat_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  blink_q;
  logic                  lit;

  rise_detect u_tick (
    .MegaClk (MegaClk),
    .reset   (reset),
    .level_i (scan_tick),
    .pulse_o (tick)
  );

  always_ff @(posedge MegaClk) begin
    if (reset) begin
      state_q <= DRIVE;
      dig_q   <= DIG_LAST;
      sub_q   <= SUB_LAST;
      pat_q   <= SEG_BLANK;
      bri_q   <= '0;
      blink_q <= 1'b0;
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      sub_q   <= sub_d;
      pat_q   <= pat_d;
      bri_q   <= bri_d;
      blink_q <= blink_clk;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  // Outputs are computed from next-state values so the registered drive
  // lines up with the counter update; blink uses the already-registered phase.
  always_comb begin
    state_d = DRIVE;
    dig_d   = dig_q;
    sub_d   = sub_q;
    pat_d   = pat_q;
    bri_d   = bri_q;
    if (tick && state_q == DRIVE) begin
      if (sub_q == SUB_LAST) begin
        sub_d   = '0;
        dig_d   = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
        pat_d   = digit_bits[dig_d];
        bri_d   = brightness;
        state_d = GUARD;
      end else begin
        sub_d = sub_q + PWM_BITS'(1);
      end
    end
    lit     = (state_d == DRIVE) && (sub_d <= bri_d) && !(blink_mask[dig_d] && blink_q);
    anode_d = lit ? NUM_DIGITS'(onehot_low(32'(dig_d), NUM_DIGITS)) : ANODE_OFF;
    seg_d   = lit ? pat_d : SEG_BLANK;
  end

  assign anode_n = anode_q;
  assign seg_n   = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: 4-, 6- and 1-digit instances checked every cycle
// against a tick-count model, plus directed literal checks.
module tb_seg_scan_driver;

  logic MegaClk = 1'b0;
  always #5 MegaClk = ~MegaClk;

  logic       reset      = 1'b1;
  logic       scan_tick  = 1'b0;
  logic       blink_clk  = 1'b0;
  logic [3:0] blink_mask = '0;
  logic [5:0] bm6        = '0;
  logic [0:0] bm1        = '0;
  logic [2:0] brightness = 3'd7;
  logic [7:0] db4 [4];
  logic [7:0] db6 [6];
  logic [7:0] db1 [1];

  logic [3:0] an4;
  logic [5:0] an6;
  logic [0:0] an1;
  logic [7:0] seg4, seg6, seg1;

  int         vectors = 0;
  int         errors  = 0;
  bit         chk_en  = 1'b0;
  bit         meas    = 1'b0;
  int         lit_cnt = 0;
  logic [5:0] seen6   = '0;

  seg_scan_driver #(.NUM_DIGITS(4), .SEG_W(8), .PWM_BITS(3)) u_dut4 (
    .MegaClk(MegaClk), .reset(reset), .scan_tick(scan_tick), .blink_clk(blink_clk),
    .blink_mask(blink_mask), .brightness(brightness), .digit_bits(db4),
    .anode_n(an4), .seg_n(seg4)
  );

  seg_scan_driver #(.NUM_DIGITS(6), .SEG_W(8), .PWM_BITS(3)) u_dut6 (
    .MegaClk(MegaClk), .reset(reset), .scan_tick(scan_tick), .blink_clk(blink_clk),
    .blink_mask(bm6), .brightness(brightness), .digit_bits(db6),
    .anode_n(an6), .seg_n(seg6)
  );

  seg_scan_driver #(.NUM_DIGITS(1), .SEG_W(8), .PWM_BITS(3)) u_dut1 (
    .MegaClk(MegaClk), .reset(reset), .scan_tick(scan_tick), .blink_clk(blink_clk),
    .blink_mask(bm1), .brightness(brightness), .digit_bits(db1),
    .anode_n(an1), .seg_n(seg1)
  );

  function automatic int nd(input int k);
    return (k == 0) ? 4 : (k == 1) ? 6 : 1;
  endfunction

  function automatic logic [7:0] pat_of(input int k, input int d);
    if (k == 0) return db4[2'(d)];
    if (k == 1) return db6[3'(d)];
    return db1[0];
  endfunction

  function automatic logic mask_of(input int k, input int d);
    if (k == 0) return blink_mask[2'(d)];
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count accepted ticks since reset; digit = slot index mod N,
  // sub-phase = tick index mod 8, slot-start ticks give one blank cycle.
  int         m_ticks = 0;
  logic       m_prev  = 1'b0;
  logic       m_blink = 1'b0;
  logic [7:0] m_pat  [3];
  int         m_bri  [3] = '{0, 0, 0};
  logic [7:0] exp_an [3];
  logic [7:0] exp_seg[3];

  always @(posedge MegaClk) begin
    int t, d, s;
    bit st;
    logic [7:0] full;
    if (reset) begin
      m_ticks <= 0;
      m_prev  <= 1'b0;
      m_blink <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        exp_an[k]  <= (8'd1 << nd(k)) - 8'd1;
        exp_seg[k] <= 8'hFF;
      end
    end else begin
      t  = m_ticks;
      st = 1'b0;
      if (scan_tick && !m_prev) begin
        t  = t + 1;
        st = ((t - 1) % 8 == 0);
      end
      for (int k = 0; k < 3; k++) begin
        full = (8'd1 << nd(k)) - 8'd1;
        d = (t > 0) ? ((t - 1) / 8) % nd(k) : 0;
        s = (t > 0) ? (t - 1) % 8 : 7;
        if (st) begin
          m_pat[k] <= pat_of(k, d);
          m_bri[k] <= int'(brightness);
        end
        if (st || t == 0 || s > m_bri[k] || (mask_of(k, d) && m_blink)) begin
          exp_an[k]  <= full;
          exp_seg[k] <= 8'hFF;
        end else begin
          exp_an[k]  <= full & ~(8'd1 << d);
          exp_seg[k] <= m_pat[k];
        end
      end
      m_ticks <= t;
      m_prev  <= scan_tick;
      m_blink <= blink_clk;
    end
  end

  always @(negedge MegaClk) begin
    if (chk_en) begin
      check("model_an4",  {28'd0, an4},  {24'd0, exp_an[0]});
      check("model_seg4", {24'd0, seg4}, {24'd0, exp_seg[0]});
      check("model_an6",  {26'd0, an6},  {24'd0, exp_an[1]});
      check("model_seg6", {24'd0, seg6}, {24'd0, exp_seg[1]});
      check("model_an1",  {31'd0, an1},  {24'd0, exp_an[2]});
      check("model_seg1", {24'd0, seg1}, {24'd0, exp_seg[2]});
      seen6 <= seen6 | ~an6;
    end
  end

  task automatic sample_duty();
    if (meas && an4 != 4'hF) lit_cnt++;
  endtask

  // One tick every 4 cycles: strobe high for 2, low for 2.
  task automatic do_tick();
    scan_tick = 1'b1;
    @(negedge MegaClk); sample_duty();
    @(negedge MegaClk); sample_duty();
    scan_tick = 1'b0;
    @(negedge MegaClk); sample_duty();
    @(negedge MegaClk); sample_duty();
  endtask

  task automatic first_slot();
    scan_tick = 1'b1;
    @(negedge MegaClk);
    check("guard_an4",  an4,  4'hF);
    check("guard_seg4", seg4, 8'hFF);
    check("guard_an1",  an1,  1'b1);
    @(negedge MegaClk);
    scan_tick = 1'b0;
    check("first_an4",  an4,  4'b1110);
    check("first_seg4", seg4, 8'hC0);
    check("first_an6",  an6,  6'b111110);
    check("first_an1",  an1,  1'b0);
    repeat (2) @(negedge MegaClk);
  endtask

  initial begin
    db4 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    db6 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    db1 = '{8'hC0};
    repeat (3) @(negedge MegaClk);
    chk_en = 1'b1;
    check("reset_an4",  an4,  4'hF);
    check("reset_seg4", seg4, 8'hFF);
    check("reset_an6",  an6,  6'h3F);
    reset = 1'b0;

    first_slot();
    repeat (31) do_tick();
    check("slot3_an4",  an4,  4'b0111);
    check("slot3_seg4", seg4, 8'hB0);

    brightness = 3'd2;
    meas = 1'b1;
    lit_cnt = 0;
    repeat (8) do_tick();
    meas = 1'b0;
    check("duty_lit_cycles", lit_cnt, 11);

    brightness = 3'd7;
    blink_mask = 4'b0100;
    repeat (10) do_tick();
    check("blink_pre_an4", an4, 4'b1011);
    blink_clk = 1'b1;
    @(negedge MegaClk);
    check("blink_lat1_an4", an4, 4'b1011);
    @(negedge MegaClk);
    check("blink_dark_an4", an4, 4'hF);
    check("blink_other_an6", an6, 6'b111110);
    blink_clk = 1'b0;
    @(negedge MegaClk);
    check("blink_hold_an4", an4, 4'hF);
    @(negedge MegaClk);
    check("blink_back_an4", an4, 4'b1011);

    repeat (25) do_tick();
    db4[1] = 8'h80;
    do_tick();
    check("midslot_old_an4",  an4,  4'b1101);
    check("midslot_old_seg4", seg4, 8'hF9);
    repeat (29) do_tick();
    check("next_visit_an4",  an4,  4'b1101);
    check("next_visit_seg4", seg4, 8'h80);

    scan_tick = 1'b1;
    repeat (50) @(negedge MegaClk);
    scan_tick = 1'b0;
    repeat (2) @(negedge MegaClk);
    check("held_tick_an4", an4, 4'b1101);

    repeat (3) do_tick();
    scan_tick = 1'b1;
    @(negedge MegaClk);
    reset = 1'b1;
    scan_tick = 1'b0;
    @(negedge MegaClk);
    check("midreset_an4",  an4,  4'hF);
    check("midreset_seg4", seg4, 8'hFF);
    check("midreset_an6",  an6,  6'h3F);
    check("midreset_an1",  an1,  1'b1);
    reset = 1'b0;
    @(negedge MegaClk);
    first_slot();
    repeat (20) do_tick();
    check("seen_all6", seen6, 6'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
